clk_div_ctrl: RTL and testbench
===============================

CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

Interface
REQ-001 Parameter W, default 8, width of divide value and counter.
REQ-002 Parameter DEFAULT_DIV, default 50, half-period in clk cycles loaded at reset.
REQ-003 clk  in  1  system clock; reset  in  1  synchronous, active-high reset.
REQ-004 run  in  1  level; 1 = generate divided clock, 0 = stop at safe boundary.
REQ-005 cfg_valid  in  1  new divide value offered.
REQ-006 cfg_div  in  W  requested half-period in clk cycles.
REQ-007 cfg_ready  out  1  controller can accept cfg_div this cycle.
REQ-008 clk_out  out  1  registered divided clock level.
REQ-009 tick  out  1  one-cycle pulse, high only in the first cycle clk_out is 1.
REQ-010 busy  out  1  a ratio change is accepted but not yet applied.
REQ-011 cur_div  out  W  half-period currently in effect.

Function
REQ-012 States SHALL be STOP, RUN, PEND; a W-bit counter cnt and a W-bit pend_div register SHALL exist.
REQ-013 cfg_ready SHALL be 1 in STOP and RUN, 0 in PEND and during reset; a transfer occurs when cfg_valid and cfg_ready are both 1 on a clk edge.
REQ-014 STOP: clk_out=0, cnt=0; a transfer loads cur_div next cycle; run=1 moves to RUN next cycle (transfer and run in the same cycle: RUN starts with the new value).
REQ-015 RUN/PEND: cnt SHALL increment each cycle; when cnt==cur_div-1, cnt SHALL clear to 0 and clk_out SHALL toggle, giving half-period cur_div and period 2*cur_div cycles.
REQ-016 A transfer in RUN SHALL store cfg_div in pend_div, set busy=1 and enter PEND; cur_div SHALL stay unchanged.
REQ-017 PEND: at the edge where clk_out falls (cnt==cur_div-1, clk_out==1), cur_div<=pend_div, cnt<=0, busy<=0, state->RUN; the following low phase uses the new value.
REQ-018 run=0 in RUN/PEND with clk_out==0: STOP next cycle, cnt cleared; pending change (if any) applied to cur_div, busy cleared.
REQ-019 run=0 with clk_out==1: high phase completes, then STOP at the falling edge with clk_out=0 (no runt high pulse); pending change applied there.
REQ-020 cfg_div==0 SHALL be treated as 1 (half-period of one cycle) when the bypass macro is undefined.
REQ-021 cnt SHALL never wrap; a value written while counting is only applied at a boundary, so cnt < cur_div always holds.
REQ-022 tick SHALL be registered and assert exactly once per clk_out period.

Reset
REQ-023 reset SHALL force: state STOP, cnt 0, clk_out 0, tick 0, busy 0, pend_div 0, cur_div DEFAULT_DIV.
REQ-024 reset mid-operation SHALL abort any pending change and win over run/cfg_valid in the same cycle.

Configuration
REQ-025 Macro CLK_DIV_CTRL_BYPASS_EN: when defined, cur_div==0 means bypass: clk_out held 0, tick=1 every cycle in RUN, cnt held 0; changes to/from 0 still obey the PEND/boundary rules (bypass exit is immediate, no high phase exists).
REQ-026 Without CLK_DIV_CTRL_BYPASS_EN, REQ-020 applies and no bypass logic is synthesized.

Verification
REQ-027 Reset, then run=1 with DEFAULT_DIV=50 -> clk_out rises 50 cycles after RUN entry, period 100, tick once per period, cur_div=50.
REQ-028 In STOP, transfer cfg_div=3 with run=1 same cycle -> cur_div=3, clk_out period 6 cycles, first rise 3 cycles after RUN entry.
REQ-029 Running at 3, transfer cfg_div=5 mid-high-phase -> busy=1, cfg_ready=0, old 3-cycle high phase completes, next low phase 5 cycles, busy=0 on same edge.
REQ-030 run=0 while clk_out=1 at cnt=0, div=4 -> clk_out stays high 4 cycles total, then 0, state STOP, no further ticks.
REQ-031 cfg_div=0 -> without macro: period 2 cycles, tick every 2nd cycle; with CLK_DIV_CTRL_BYPASS_EN: tick every cycle, clk_out=0.
REQ-032 Assert reset during PEND -> next cycle busy=0, clk_out=0, cur_div=DEFAULT_DIV, cfg_ready=1 after reset released.

Source files
------------

// File: rtl/clk_div_ctrl.sv
// rtl/clk_div_ctrl.sv - programmable clock divider with boundary-safe ratio changes
// Optional feature: CLK_DIV_CTRL_BYPASS_EN (cur_div==0 selects bypass).
module clk_div_ctrl #(
  parameter int W           = 8,
  parameter int DEFAULT_DIV = 50
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         run,
  input  logic         cfg_valid,
  input  logic [W-1:0] cfg_div,
  output logic         cfg_ready,
  output logic         clk_out,
  output logic         tick,
  output logic         busy,
  output logic [W-1:0] cur_div
);

  localparam logic [1:0] STOP = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] PEND = 2'd2;

  logic [1:0]   state;
  logic [W-1:0] cnt;
  logic [W-1:0] pend_div;
  logic [W-1:0] cfg_val;
  logic [W-1:0] last;
  logic         xfer;
  logic         boundary;

  assign cfg_ready = !reset && (state != PEND);
  assign xfer      = cfg_valid && cfg_ready;

`ifdef CLK_DIV_CTRL_BYPASS_EN
  logic bypass;
  assign bypass  = (cur_div == '0);
  assign cfg_val = cfg_div;
`else
  // A zero request means the fastest legal ratio: one cycle per half-period.
  assign cfg_val = (cfg_div == '0) ? W'(1) : cfg_div;
`endif

  assign last     = (cur_div == '0) ? '0 : cur_div - W'(1);
  assign boundary = (cnt == last);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= STOP;
      cnt      <= '0;
      clk_out  <= 1'b0;
      tick     <= 1'b0;
      busy     <= 1'b0;
      pend_div <= '0;
      cur_div  <= W'(DEFAULT_DIV);
    end else begin
      tick <= 1'b0;
      if (state == STOP) begin
        cnt     <= '0;
        clk_out <= 1'b0;
        if (xfer) cur_div <= cfg_val;
        if (run) state <= RUN;
      end
`ifdef CLK_DIV_CTRL_BYPASS_EN
      else if (bypass && run) begin
        cnt     <= '0;
        clk_out <= 1'b0;
        tick    <= 1'b1;
        if (state == PEND) begin
          cur_div <= pend_div;
          busy    <= 1'b0;
          state   <= RUN;
        end else if (xfer) begin
          pend_div <= cfg_val;
          busy     <= 1'b1;
          state    <= PEND;
        end
      end
`endif
      else if (!run && !clk_out) begin
        // Stopping during the low phase is always glitch-free.
        state <= STOP;
        cnt   <= '0;
        busy  <= 1'b0;
        if (state == PEND) cur_div <= pend_div;
        else if (xfer)     cur_div <= cfg_val;
      end else if (boundary) begin
        cnt     <= '0;
        clk_out <= ~clk_out;
        tick    <= ~clk_out;
        if (clk_out) begin
          if (state == PEND) begin
            cur_div <= pend_div;
            busy    <= 1'b0;
          end
          if (!run) begin
            state <= STOP;
            if (xfer) cur_div <= cfg_val;
          end else if (xfer) begin
            pend_div <= cfg_val;
            busy     <= 1'b1;
            state    <= PEND;
          end else begin
            state <= RUN;
          end
        end else if (xfer) begin
          pend_div <= cfg_val;
          busy     <= 1'b1;
          state    <= PEND;
        end
      end else begin
        cnt <= cnt + W'(1);
        if (xfer) begin
          pend_div <= cfg_val;
          busy     <= 1'b1;
          state    <= PEND;
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb/tb_clk_div_ctrl.sv - randomized and directed checks of clk_div_ctrl against a phase model
module tb_clk_div_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       run;
  logic       cfg_valid;
  logic [7:0] cfg_div;
  logic       cfg_ready;
  logic       clk_out;
  logic       tick;
  logic       busy;
  logic [7:0] cur_div;

  int errors = 0;
  int checks = 0;

  // Model: phase level, cycles left in the phase, ratio in effect, pending ratio.
  logic       m_stopped;
  logic       m_level;
  logic       m_tick;
  int         m_left;
  logic [7:0] m_cur;
  logic       m_pend_ok;
  logic [7:0] m_pend;

  clk_div_ctrl #(.W(8), .DEFAULT_DIV(50)) dut (
    .clk(clk), .reset(reset), .run(run), .cfg_valid(cfg_valid), .cfg_div(cfg_div),
    .cfg_ready(cfg_ready), .clk_out(clk_out), .tick(tick), .busy(busy), .cur_div(cur_div)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    logic       xfer;
    logic [7:0] val;
    if (reset) begin
      m_stopped = 1'b1; m_level = 1'b0; m_tick = 1'b0;
      m_pend_ok = 1'b0; m_pend = '0; m_cur = 8'd50; m_left = 0;
      return;
    end
    xfer   = cfg_valid && !m_pend_ok;
    val    = (cfg_div == 0) ? 8'd1 : cfg_div;
    m_tick = 1'b0;
    if (m_stopped) begin
      if (xfer) m_cur = val;
      if (run) begin m_stopped = 1'b0; m_level = 1'b0; m_left = m_cur; end
    end else if (!run && !m_level) begin
      m_stopped = 1'b1;
      if (m_pend_ok) m_cur = m_pend;
      else if (xfer) m_cur = val;
      m_pend_ok = 1'b0;
    end else begin
      m_left--;
      if (m_left == 0) begin
        m_level = !m_level;
        m_tick  = m_level;
        if (!m_level) begin
          if (m_pend_ok) begin m_cur = m_pend; m_pend_ok = 1'b0; end
          if (!run) m_stopped = 1'b1;
        end
        m_left = m_cur;
      end
      if (xfer) begin
        if (m_stopped) m_cur = val;
        else begin m_pend = val; m_pend_ok = 1'b1; end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("clk_out", clk_out, m_level);
    check("tick", tick, m_tick);
    check("busy", busy, m_pend_ok);
    check("cur_div", cur_div, m_cur);
    check("cfg_ready", cfg_ready, !reset && !m_pend_ok);
  endtask

  task automatic count_until(input logic lvl, output int n);
    n = 0;
    while (clk_out !== lvl && n < 300) begin step(); n++; end
  endtask

  task automatic count_tick(output int n);
    n = 0;
    do begin step(); n++; end while (tick !== 1'b1 && n < 300);
  endtask

  task automatic do_reset();
    reset = 1'b1; run = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
    step();
    reset = 1'b0;
  endtask

  initial begin
    int n;
    int ticks;
    reset = 1'b1; run = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
    step();
    step();
    check("rst_cur_div", cur_div, 50);
    check("rst_ready_in_reset", cfg_ready, 0);
    reset = 1'b0;
    step();
    check("ready_after_reset", cfg_ready, 1);

    // Default ratio: first rise 50 cycles after RUN entry, period 100
    run = 1'b1;
    step();
    count_until(1'b1, n);
    check("def_first_rise", n, 50);
    check("def_tick_on_rise", tick, 1);
    count_tick(n);
    check("def_period", n, 100);

    // Load 3 in STOP together with run
    do_reset();
    cfg_valid = 1'b1; cfg_div = 8'd3; run = 1'b1;
    step();
    cfg_valid = 1'b0;
    check("load3_cur", cur_div, 3);
    count_until(1'b1, n);
    check("load3_first_rise", n, 3);
    count_tick(n);
    check("load3_period", n, 6);

    // Change to 5 during the first high cycle
    cfg_valid = 1'b1; cfg_div = 8'd5;
    step();
    cfg_valid = 1'b0;
    check("chg_busy", busy, 1);
    check("chg_ready", cfg_ready, 0);
    check("chg_cur_held", cur_div, 3);
    count_until(1'b0, n);
    check("chg_old_high_len", n + 1, 3);
    check("chg_busy_cleared", busy, 0);
    check("chg_cur_new", cur_div, 5);
    count_until(1'b1, n);
    check("chg_new_low_len", n, 5);

    // Stop during the first high cycle at ratio 4
    do_reset();
    cfg_valid = 1'b1; cfg_div = 8'd4; run = 1'b1;
    step();
    cfg_valid = 1'b0;
    count_until(1'b1, n);
    run = 1'b0;
    count_until(1'b0, n);
    check("stop_high_len", n, 4);
    ticks = 0;
    for (int i = 0; i < 20; i++) begin step(); ticks += int'(tick); end
    check("stop_no_ticks", ticks, 0);
    check("stop_clk_low", clk_out, 0);

    // Zero ratio behaves as 1
    do_reset();
    cfg_valid = 1'b1; cfg_div = 8'd0; run = 1'b1;
    step();
    cfg_valid = 1'b0;
    check("zero_cur", cur_div, 1);
    ticks = 0;
    for (int i = 0; i < 20; i++) begin step(); ticks += int'(tick); end
    check("zero_ticks_20", ticks, 10);

    // Reset while a change is pending
    do_reset();
    cfg_valid = 1'b1; cfg_div = 8'd4; run = 1'b1;
    step();
    cfg_valid = 1'b0;
    step(); step(); step();
    cfg_valid = 1'b1; cfg_div = 8'd7;
    step();
    cfg_valid = 1'b0;
    check("pend_busy", busy, 1);
    reset = 1'b1;
    step();
    check("pend_rst_busy", busy, 0);
    check("pend_rst_clk", clk_out, 0);
    check("pend_rst_cur", cur_div, 50);
    reset = 1'b0; run = 1'b0;
    step();
    check("pend_rst_ready", cfg_ready, 1);

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      reset     = ($urandom_range(0, 299) == 0);
      run       = ($urandom_range(0, 9) != 0);
      cfg_valid = ($urandom_range(0, 7) == 0);
      cfg_div   = 8'($urandom_range(0, 6));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
